// File: rtl/cx_arb_pkg.sv
// Shared types and constants for the uplink arbiter: FSM states, grant
// owner and the packed width of one mic FIFO entry.
package cx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MIC_FRAME,
    BME_HI,
    BME_LO
  } arb_state_e;

  typedef enum logic {
    MIC,
    BME
  } grant_e;

  // {data[31:0], channel[4:0], error[1:0]}
  localparam int MIC_ENTRY_W = 39;

endpackage

// File: rtl/cx_sync_fifo.sv
// Single-clock FIFO whose head sits in a dedicated output register, so read
// data is always registered and a write takes two edges to reach the head.
module cx_sync_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      memCount_q, memCount_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             headValid_q, headValid_d;
  logic [AW:0]      total;
  logic             pop, push, load;

  // Occupancy counts the head register too, so full means DEPTH words held.
  assign total   = memCount_q + {{AW{1'b0}}, headValid_q};
  assign full_o  = (total == (AW+1)'(DEPTH));
  assign empty_o = (total == '0);

  assign pop  = rd_en_i && headValid_q;
  assign push = wr_en_i && (!full_o || pop);
  assign load = (memCount_q != '0) && (!headValid_q || pop);

  assign rd_data_o  = head_q;
  assign rd_valid_o = headValid_q;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    head_d      = head_q;
    headValid_d = headValid_q;
    memCount_d  = memCount_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (load) begin
      rdPtr_d     = rdPtr_q + AW'(1);
      head_d      = mem_q[rdPtr_q];
      headValid_d = 1'b1;
    end else if (pop) begin
      headValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      memCount_q  <= '0;
      head_q      <= '0;
      headValid_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      memCount_q  <= memCount_d;
      head_q      <= head_d;
      headValid_q <= headValid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cx_uplink_arbiter.sv
// Merges the mic frame stream and BME samples into one 32-bit uplink,
// round-robin per packet, with resync of broken mic frames and sticky flags.
module cx_uplink_arbiter
  import cx_arb_pkg::*;
#(
  parameter int NUM_MIC_CH     = 16,
  parameter int MIC_FIFO_DEPTH = 32,
  parameter int BME_CHANNEL    = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mic_data,
  input  logic [4:0]  mic_channel,
  input  logic [1:0]  mic_error,
  input  logic        mic_valid,
  input  logic [63:0] bme_data,
  input  logic [1:0]  bme_error,
  input  logic        bme_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_channel,
  output logic [1:0]  out_error,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clear_flags,
  output logic        mic_overflow,
  output logic        bme_overflow,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [4:0] LAST_CH = 5'(NUM_MIC_CH - 1);
  localparam logic [4:0] BME_CH  = 5'(BME_CHANNEL);

  logic [MIC_ENTRY_W-1:0] fifoHead;
  logic                   fifoHeadValid, fifoFull, fifoEmpty, fifoPop;
  logic [31:0]            headData;
  logic [4:0]             headCh;
  logic [1:0]             headErr;

  arb_state_e  state_q, state_d;
  grant_e      lastGrant_q, lastGrant_d;
  logic [4:0]  expCh_q, expCh_d;
  logic [63:0] bmeData_q, bmeData_d;
  logic [1:0]  bmeErr_q, bmeErr_d;
  logic        bmeFull_q, bmeFull_d;
  logic        micOvf_q, micOvf_d;
  logic        bmeOvf_q, bmeOvf_d;
  logic        frameErr_q, frameErr_d;

  logic        micCand, isLast, frameErrSet, bmeFree, bmeLoad, micDrop, bmeDrop;

  cx_sync_fifo #(
    .WIDTH(MIC_ENTRY_W),
    .DEPTH(MIC_FIFO_DEPTH)
  ) u_mic_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .wr_en_i    (mic_valid),
    .wr_data_i  ({mic_data, mic_channel, mic_error}),
    .rd_en_i    (fifoPop),
    .rd_data_o  (fifoHead),
    .rd_valid_o (fifoHeadValid),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign headData = fifoHead[38:7];
  assign headCh   = fifoHead[6:2];
  assign headErr  = fifoHead[1:0];
  assign micCand  = fifoHeadValid && (headCh == '0);
  assign isLast   = (expCh_q == LAST_CH);

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    expCh_d     = expCh_q;
    fifoPop     = 1'b0;
    frameErrSet = 1'b0;
    bmeFree     = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_channel = '0;
    out_error   = '0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A non-zero channel at the head can never start a frame; drop it.
        if (fifoHeadValid && (headCh != '0)) begin
          fifoPop     = 1'b1;
          frameErrSet = 1'b1;
        end
        if (micCand && (!bmeFull_q || (lastGrant_q == BME))) begin
          state_d = MIC_FRAME;
          expCh_d = '0;
        end else if (bmeFull_q) begin
          state_d = BME_HI;
        end
      end
      MIC_FRAME: begin
        if (fifoHeadValid) begin
          if (headCh == expCh_q) begin
            out_valid   = 1'b1;
            out_data    = headData;
            out_channel = headCh;
            out_error   = headErr;
            out_sop     = (expCh_q == '0);
            out_eop     = isLast;
            if (out_ready) begin
              fifoPop = 1'b1;
              expCh_d = expCh_q + 5'd1;
              if (isLast) begin
                state_d     = IDLE;
                lastGrant_d = MIC;
              end
            end
          end else if (headCh == '0) begin
            // Leave the channel-0 word in place so it opens the next frame.
            frameErrSet = 1'b1;
            state_d     = IDLE;
          end else begin
            fifoPop     = 1'b1;
            frameErrSet = 1'b1;
          end
        end
      end
      BME_HI: begin
        out_valid   = 1'b1;
        out_data    = bmeData_q[63:32];
        out_channel = BME_CH;
        out_error   = bmeErr_q;
        out_sop     = 1'b1;
        if (out_ready) begin
          state_d = BME_LO;
        end
      end
      BME_LO: begin
        out_valid   = 1'b1;
        out_data    = bmeData_q[31:0];
        out_channel = BME_CH;
        out_error   = bmeErr_q;
        out_eop     = 1'b1;
        if (out_ready) begin
          bmeFree     = 1'b1;
          lastGrant_d = BME;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bmeLoad = bme_valid && (!bmeFull_q || bmeFree);
  assign bmeDrop = bme_valid && !bmeLoad;
  assign micDrop = mic_valid && fifoFull && !fifoPop;

  always_comb begin
    bmeData_d = bmeData_q;
    bmeErr_d  = bmeErr_q;
    bmeFull_d = bmeFull_q;
    if (bmeLoad) begin
      bmeData_d = bme_data;
      bmeErr_d  = bme_error;
      bmeFull_d = 1'b1;
    end else if (bmeFree) begin
      bmeFull_d = 1'b0;
    end
    // A set event in the same cycle as clear_flags keeps the flag high.
    micOvf_d   = micDrop     || (micOvf_q   && !clear_flags);
    bmeOvf_d   = bmeDrop     || (bmeOvf_q   && !clear_flags);
    frameErr_d = frameErrSet || (frameErr_q && !clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= BME;
      expCh_q     <= '0;
      bmeData_q   <= '0;
      bmeErr_q    <= '0;
      bmeFull_q   <= 1'b0;
      micOvf_q    <= 1'b0;
      bmeOvf_q    <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      expCh_q     <= expCh_d;
      bmeData_q   <= bmeData_d;
      bmeErr_q    <= bmeErr_d;
      bmeFull_q   <= bmeFull_d;
      micOvf_q    <= micOvf_d;
      bmeOvf_q    <= bmeOvf_d;
      frameErr_q  <= frameErr_d;
    end
  end

  assign mic_overflow = micOvf_q;
  assign bme_overflow = bmeOvf_q;
  assign frame_error  = frameErr_q;
  assign busy         = (state_q != IDLE) || !fifoEmpty || bmeFull_q;

endmodule

// File: tb/tb_cx_uplink_arbiter.sv
// Scoreboard bench for cx_uplink_arbiter: expected uplink words are queued as
// stimulus is driven and compared when the DUT hands them to the serializer.
module tb_cx_uplink_arbiter;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int BME_CH = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mic_data;
  logic [4:0]  mic_channel;
  logic [1:0]  mic_error;
  logic        mic_valid;
  logic [63:0] bme_data;
  logic [1:0]  bme_error;
  logic        bme_valid;
  logic [31:0] out_data;
  logic [4:0]  out_channel;
  logic [1:0]  out_error;
  logic        out_sop;
  logic        out_eop;
  logic        out_valid;
  logic        out_ready;
  logic        clear_flags;
  logic        mic_overflow;
  logic        bme_overflow;
  logic        frame_error;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  ch;
    logic [1:0]  err;
    logic        sop;
    logic        eop;
  } word_t;

  word_t expQ[$];
  word_t gotExp;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  cx_uplink_arbiter #(
    .NUM_MIC_CH    (NUM_CH),
    .MIC_FIFO_DEPTH(DEPTH),
    .BME_CHANNEL   (BME_CH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mic_data    (mic_data),
    .mic_channel (mic_channel),
    .mic_error   (mic_error),
    .mic_valid   (mic_valid),
    .bme_data    (bme_data),
    .bme_error   (bme_error),
    .bme_valid   (bme_valid),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_error   (out_error),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear_flags (clear_flags),
    .mic_overflow(mic_overflow),
    .bme_overflow(bme_overflow),
    .frame_error (frame_error),
    .busy        (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every accepted word must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checkOutput("sb_has_entry", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        gotExp = expQ.pop_front();
        checkOutput("out_data", 64'(out_data), 64'(gotExp.data));
        checkOutput("out_channel", 64'(out_channel), 64'(gotExp.ch));
        checkOutput("out_error", 64'(out_error), 64'(gotExp.err));
        checkOutput("out_sop_eop", 64'({out_sop, out_eop}), 64'({gotExp.sop, gotExp.eop}));
      end
    end
  end

  task automatic pushWord(input logic [31:0] d, input logic [4:0] ch, input logic [1:0] e,
                          input logic s, input logic eo);
    word_t w;
    w.data = d; w.ch = ch; w.err = e; w.sop = s; w.eop = eo;
    expQ.push_back(w);
  endtask

  task automatic pushFrame(input logic [31:0] base);
    for (int i = 0; i < NUM_CH; i++) begin
      pushWord(base + 32'(i), 5'(i), 2'(i), i == 0, i == NUM_CH - 1);
    end
  endtask

  task automatic pushBme(input logic [63:0] d, input logic [1:0] e);
    pushWord(d[63:32], 5'(BME_CH), e, 1'b1, 1'b0);
    pushWord(d[31:0], 5'(BME_CH), e, 1'b0, 1'b1);
  endtask

  // One clock of input strobes; entered and left just after a rising edge.
  task automatic applyStimulus(input logic mv, input logic [31:0] md, input logic [4:0] mc,
                               input logic [1:0] me, input logic bv, input logic [63:0] bd,
                               input logic [1:0] be);
    mic_valid = mv; mic_data = md; mic_channel = mc; mic_error = me;
    bme_valid = bv; bme_data = bd; bme_error = be;
    @(posedge clk);
    #1;
    mic_valid = 1'b0;
    bme_valid = 1'b0;
  endtask

  task automatic sendMic(input logic [31:0] d, input logic [4:0] ch);
    applyStimulus(1'b1, d, ch, ch[1:0], 1'b0, 64'd0, 2'd0);
  endtask

  task automatic sendFrame(input logic [31:0] base);
    for (int i = 0; i < NUM_CH; i++) sendMic(base + 32'(i), 5'(i));
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulseClear();
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; mic_valid = 1'b0; mic_data = '0; mic_channel = '0; mic_error = '0;
    bme_valid = 1'b0; bme_data = '0; bme_error = '0; out_ready = 1'b1; clear_flags = 1'b0;
    doReset();
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_ctrl", 64'({out_sop, out_eop, out_channel, out_error}), 64'd0);
    checkOutput("rst_flags", 64'({mic_overflow, bme_overflow, frame_error}), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);

    $display("[TB] single frame");
    pushFrame(32'h100);
    sendFrame(32'h100);
    waitDrain("single");

    $display("[TB] BME sample arriving mid-frame");
    pushFrame(32'h400);
    pushBme(64'h1122334455667788, 2'b10);
    sendMic(32'h400, 5'd0);
    sendMic(32'h401, 5'd1);
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 64'h1122334455667788, 2'b10);
    sendMic(32'h402, 5'd2);
    sendMic(32'h403, 5'd3);
    waitDrain("midframe");
    checkOutput("midframe_bme_ovf", 64'(bme_overflow), 64'd0);

    $display("[TB] ties: mic after reset, mic after BME, BME after mic");
    doReset();
    pushFrame(32'h500);
    pushBme(64'hA1A2A3A4B1B2B3B4, 2'b01);
    sendMic(32'h500, 5'd0);
    applyStimulus(1'b1, 32'h501, 5'd1, 2'd1, 1'b1, 64'hA1A2A3A4B1B2B3B4, 2'b01);
    sendMic(32'h502, 5'd2);
    sendMic(32'h503, 5'd3);
    waitDrain("tie_reset");

    pushFrame(32'h600);
    pushBme(64'hC1C2C3C4D1D2D3D4, 2'b11);
    sendMic(32'h600, 5'd0);
    applyStimulus(1'b1, 32'h601, 5'd1, 2'd1, 1'b1, 64'hC1C2C3C4D1D2D3D4, 2'b11);
    sendMic(32'h602, 5'd2);
    sendMic(32'h603, 5'd3);
    waitDrain("tie_after_bme");

    pushFrame(32'h700);
    sendFrame(32'h700);
    waitDrain("lone_frame");

    pushBme(64'hE1E2E3E4F1F2F3F4, 2'b00);
    pushFrame(32'h800);
    sendMic(32'h800, 5'd0);
    applyStimulus(1'b1, 32'h801, 5'd1, 2'd1, 1'b1, 64'hE1E2E3E4F1F2F3F4, 2'b00);
    sendMic(32'h802, 5'd2);
    sendMic(32'h803, 5'd3);
    waitDrain("tie_after_mic");

    $display("[TB] backpressure on second word");
    out_ready = 1'b0;
    pushFrame(32'h100);
    sendFrame(32'h100);
    waitValid("bp_first");
    checkOutput("bp_first_data", 64'(out_data), 64'h100);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_data", 64'(out_data), 64'h101);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    waitDrain("backpressure");

    $display("[TB] mic FIFO overflow");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH) pushWord(32'h200 + 32'(i), 5'(i % 4), 2'(i % 4), (i % 4) == 0, (i % 4) == 3);
      sendMic(32'h200 + 32'(i), 5'(i % 4));
      if (i == DEPTH - 1) checkOutput("ovf_before_full", 64'(mic_overflow), 64'd0);
      if (i == DEPTH) checkOutput("ovf_on_ninth", 64'(mic_overflow), 64'd1);
    end
    out_ready = 1'b1;
    waitDrain("overflow");
    checkOutput("ovf_sticky", 64'(mic_overflow), 64'd1);
    pulseClear();
    checkOutput("ovf_cleared", 64'(mic_overflow), 64'd0);

    $display("[TB] truncated frame followed by an intact one");
    checkOutput("ferr_before", 64'(frame_error), 64'd0);
    pushWord(32'h300, 5'd0, 2'd0, 1'b1, 1'b0);
    pushWord(32'h301, 5'd1, 2'd1, 1'b0, 1'b0);
    pushFrame(32'h310);
    sendMic(32'h300, 5'd0);
    sendMic(32'h301, 5'd1);
    sendFrame(32'h310);
    waitDrain("truncate");
    checkOutput("ferr_set", 64'(frame_error), 64'd1);

    $display("[TB] reset while in BME_HI");
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 64'hCAFEF00D12345678, 2'b01);
    waitValid("bmehi");
    checkOutput("bmehi_sop_ch", 64'({out_sop, out_channel}), 64'({1'b1, 5'(BME_CH)}));
    checkOutput("bmehi_data", 64'(out_data), 64'hCAFEF00D);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst2_valid", 64'(out_valid), 64'd0);
    checkOutput("rst2_data", 64'(out_data), 64'd0);
    checkOutput("rst2_ctrl", 64'({out_sop, out_eop, out_channel, out_error}), 64'd0);
    checkOutput("rst2_busy", 64'(busy), 64'd0);
    checkOutput("rst2_flags", 64'({mic_overflow, bme_overflow, frame_error}), 64'd0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst2_quiet", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
